load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, data bus width; ADDR_WIDTH, default 32, byte address width.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cpu_valid  in  1  CPU access request.
REQ-006 cpu_ready  out  1  LSU accepts request (high only in IDLE).
REQ-007 cpu_we  in  1  1 = store, 0 = load.
REQ-008 cpu_addr_mode  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 cpu_addr  in  ADDR_WIDTH  byte address.
REQ-010 cpu_wdata  in  DATA_WIDTH  store data, LSB-aligned.
REQ-011 cpu_done  out  1  one-cycle completion pulse.
REQ-012 cpu_rdata  out  DATA_WIDTH  extended load result, valid with cpu_done.
REQ-013 cpu_misalign  out  1  misaligned-access error, pulses with cpu_done.
REQ-014 mem_req  out  1  memory request, held until mem_ack.
REQ-015 mem_we  out  1  memory write.
REQ-016 mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
REQ-017 mem_wdata  out  DATA_WIDTH  lane-positioned write data.
REQ-018 mem_wstrb  out  4  byte-lane write strobes (all 0 on reads).
REQ-019 mem_ack  in  1  memory completed current access; mem_rdata valid same cycle.
REQ-020 mem_rdata  in  DATA_WIDTH  little-endian read word.

Function
REQ-021 The FSM SHALL have states IDLE, ACC0, ACC1, RESP.
REQ-022 A request SHALL be accepted on cpu_valid & cpu_ready; address, mode, we and wdata are registered that edge.
REQ-023 On acceptance, IDLE SHALL go to ACC0; mem_req rises the following cycle.
REQ-024 mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-025 On mem_ack in ACC0, the FSM SHALL go to ACC1 if the access spans two words, else to RESP.
REQ-026 On mem_ack in ACC1, the FSM SHALL go to RESP.
REQ-027 mem_req SHALL drop in the cycle after the final ack.
REQ-028 RESP SHALL last exactly one cycle: cpu_done=1, then IDLE.
REQ-029 Aligned single-word access SHALL take 2 + memory wait cycles from acceptance to cpu_done (zero-wait: done on cycle 3 after acceptance edge).
REQ-030 Byte offset o = addr[1:0]; stores SHALL shift wdata left by 8*o and set wstrb B=0001<<o, H=0011<<o, W=1111<<o (truncated to 4 bits in ACC0).
REQ-031 Loads SHALL extract byte(s) from offset o; B/H sign-extend from bit 7/15; BU/HU zero-extend; W unmodified.
REQ-032 Undefined addr_mode values (011, 110, 111) SHALL be treated as W.
REQ-033 cpu_rdata SHALL hold its value until the next cpu_done; it is 0 for stores.
REQ-034 A word access at 0xFFFFFFFC+ SHALL wrap the second word address to 0x00000000.
REQ-035 cpu_valid SHALL be ignored outside IDLE; at most one access is outstanding.

Reset
REQ-036 While rst=1 the FSM SHALL enter IDLE and clear cpu_done, cpu_misalign, mem_req, mem_we and mem_wstrb; cpu_rdata, mem_addr and mem_wdata clear to 0.
REQ-037 rst mid-access SHALL abandon the access; mem_req is 0 the cycle after the reset edge, no cpu_done is issued.

Configuration
REQ-038 Macro LSU_MISALIGN_SPLIT_EN defined: H with o=3 or W with o≠0 SHALL be split into two accesses (ACC0 word A, ACC1 word A+4 with remaining strobes/bytes); loads merge both words before extension; cpu_misalign stays 0.
REQ-039 Macro undefined: such accesses SHALL issue no memory request, go IDLE→RESP directly, and pulse cpu_done with cpu_misalign=1 and cpu_rdata=0.

Verification
REQ-040 LW addr 0x100, mem_rdata 0xDEADBEEF, zero-wait ack -> cpu_done on 3rd cycle after accept, cpu_rdata=0xDEADBEEF.
REQ-041 LB addr 0x103, mem_rdata 0x80112233 -> cpu_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-042 SH addr 0x102, wdata 0x0000ABCD -> mem_addr=0x100, mem_wstrb=1100, mem_wdata[31:16]=0xABCD.
REQ-043 SPLIT_EN: LW addr 0x101, words 0x44332211 then 0x88776655 -> two requests 0x100, 0x104; cpu_rdata=0x55443322. Without macro -> no mem_req, cpu_misalign=1.
REQ-044 mem_ack held low 5 cycles -> mem_* outputs stable throughout; rst asserted in ACC0 -> mem_req=0 next cycle, no cpu_done.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: sits between the CPU and a word-wide memory port.
// Positions store data and byte strobes on the memory lanes and extracts,
// sign- or zero-extends load data from the returned word.
// Optional build macro LSU_MISALIGN_SPLIT_EN: when defined, accesses that
// straddle a word boundary are split into two memory accesses. When
// undefined, they are rejected with cpu_misalign and never reach memory.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_addr_mode,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_misalign,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            mode_q, mode_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  misalign_q, misalign_d;

    logic [7:0]              win;
    logic                    span;
    logic [4:0]              sh;
    logic [ADDR_WIDTH-1:0]   word_base;
    logic [2*DATA_WIDTH-1:0] wdata_wide;
    logic [2*DATA_WIDTH-1:0] rdata_wide;
    logic [DATA_WIDTH-1:0]   picked;
    logic [DATA_WIDTH-1:0]   load_val;
`ifndef LSU_MISALIGN_SPLIT_EN
    logic [7:0]              in_win;
`endif

    // Byte-strobe window across two consecutive words: low nibble is the
    // first word, high nibble the second. Modes 011/110/111 fall into W.
    function automatic logic [7:0] strb_window(input logic [1:0] off, input logic [2:0] mode);
        logic [7:0] base;
        case (mode[1:0])
            2'b00:   base = 8'b0000_0001;
            2'b01:   base = 8'b0000_0011;
            default: base = 8'b0000_1111;
        endcase
        return base << off;
    endfunction

    // Lane positioning of the registered request and load-data extraction.
    always_comb begin
        win        = strb_window(addr_q[1:0], mode_q);
        span       = |win[7:4];
        sh         = {addr_q[1:0], 3'b000};
        word_base  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        wdata_wide = {{DATA_WIDTH{1'b0}}, wdata_q} << sh;
        if (state_q == ACC1) begin
            rdata_wide = {mem_rdata, lo_q};
        end else begin
            rdata_wide = {{DATA_WIDTH{1'b0}}, mem_rdata};
        end
        rdata_wide = rdata_wide >> sh;
        picked     = rdata_wide[DATA_WIDTH-1:0];
        case (mode_q[1:0])
            2'b00:   load_val = {{(DATA_WIDTH-8){picked[7] & ~mode_q[2]}}, picked[7:0]};
            2'b01:   load_val = {{(DATA_WIDTH-16){picked[15] & ~mode_q[2]}}, picked[15:0]};
            default: load_val = picked;
        endcase
    end

    // Memory-side outputs are pure functions of state and registered request,
    // so they cannot change while a request waits for its ack.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (state_q == ACC0) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = word_base;
            mem_wdata = wdata_wide[DATA_WIDTH-1:0];
            mem_wstrb = we_q ? win[3:0] : 4'b0000;
        end else if (state_q == ACC1) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = word_base + ADDR_WIDTH'(4);
            mem_wdata = wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH];
            mem_wstrb = we_q ? win[7:4] : 4'b0000;
        end
    end

    // Next-state logic: accept, issue one or two word accesses, respond.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mode_d     = mode_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
`ifndef LSU_MISALIGN_SPLIT_EN
        in_win     = strb_window(cpu_addr[1:0], cpu_addr_mode);
`endif
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    addr_d     = cpu_addr;
                    mode_d     = cpu_addr_mode;
                    we_d       = cpu_we;
                    wdata_d    = cpu_wdata;
                    misalign_d = 1'b0;
                    state_d    = ACC0;
`ifndef LSU_MISALIGN_SPLIT_EN
                    if (|in_win[7:4]) begin
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                        state_d    = RESP;
                    end
`endif
                end
            end
            ACC0: begin
                if (mem_ack) begin
                    if (span) begin
                        lo_d    = mem_rdata;
                        state_d = ACC1;
                    end else begin
                        rdata_d = we_q ? '0 : load_val;
                        state_d = RESP;
                    end
                end
            end
            ACC1: begin
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : load_val;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            mode_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            lo_q       <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mode_q     <= mode_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign cpu_ready    = (state_q == IDLE);
    assign cpu_done     = (state_q == RESP);
    assign cpu_misalign = (state_q == RESP) & misalign_q;
    assign cpu_rdata    = rdata_q;

endmodule
